// File: rtl/frame_fill.sv
// Rectangle-fill write engine for the display buffer: clips each command to the
// active area and streams one pixel write per accepted cycle, row-major.
module frame_fill #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PIXEL_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [9:0]             cmd_x0,
  input  logic [9:0]             cmd_y0,
  input  logic [9:0]             cmd_x1,
  input  logic [9:0]             cmd_y1,
  input  logic [PIXEL_WIDTH-1:0] cmd_color,
  output logic                   wr_en,
  input  logic                   wr_ready,
  output logic [19:0]            wr_address,
  output logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   done,
  output logic                   empty_cmd,
  output logic [19:0]            pixel_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
  localparam logic [9:0] H_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE - 1);

  logic [1:0]             state;
  logic [9:0]             x0_q;
  logic [9:0]             cx1;
  logic [9:0]             cy1;
  logic [9:0]             cur_x;
  logic [9:0]             cur_y;
  logic [PIXEL_WIDTH-1:0] color_q;
  logic [19:0]            counter;

  logic                   cmd_empty;
  logic [9:0]             clip_x1;
  logic [9:0]             clip_y1;
  logic                   last_x;
  logic                   last_y;
  logic [19:0]            counter_nxt;

  always_comb begin
    cmd_empty   = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) ||
                  (cmd_x0 >= H_LIM) || (cmd_y0 >= V_LIM);
    clip_x1     = (cmd_x1 > H_MAX) ? H_MAX : cmd_x1;
    clip_y1     = (cmd_y1 > V_MAX) ? V_MAX : cmd_y1;
    last_x      = (cur_x == cx1);
    last_y      = (cur_y == cy1);
    counter_nxt = counter + 20'd1;
  end

  // The cursor is the write address, so it only moves when a write is taken.
  assign wr_address = {cur_y, cur_x};
  assign wr_data    = color_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      wr_en       <= 1'b0;
      done        <= 1'b0;
      empty_cmd   <= 1'b0;
      pixel_count <= '0;
      x0_q        <= '0;
      cx1         <= '0;
      cy1         <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      color_q     <= '0;
      counter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          done      <= 1'b0;
          empty_cmd <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            x0_q      <= cmd_x0;
            cx1       <= clip_x1;
            cy1       <= clip_y1;
            color_q   <= cmd_color;
            counter   <= '0;
            if (cmd_empty) begin
              state       <= DONE;
              done        <= 1'b1;
              empty_cmd   <= 1'b1;
              pixel_count <= '0;
            end else begin
              state <= FILL;
              wr_en <= 1'b1;
              cur_x <= cmd_x0;
              cur_y <= cmd_y0;
            end
          end
        end
        FILL: begin
          if (wr_en && wr_ready) begin
            counter <= counter_nxt;
            if (!last_x) begin
              cur_x <= cur_x + 10'd1;
            end else if (!last_y) begin
              cur_x <= x0_q;
              cur_y <= cur_y + 10'd1;
            end else begin
              wr_en       <= 1'b0;
              state       <= DONE;
              done        <= 1'b1;
              pixel_count <= counter_nxt;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          empty_cmd <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fill.sv
// Directed bench for frame_fill: a scoreboard of expected writes and done
// results is filled when commands are issued and drained as the DUT responds.
module tb_frame_fill;

  localparam int PW = 24;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [9:0]    cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [PW-1:0] cmd_color;
  logic          wr_en;
  logic          wr_ready;
  logic [19:0]   wr_address;
  logic [PW-1:0] wr_data;
  logic          done;
  logic          empty_cmd;
  logic [19:0]   pixel_count;

  frame_fill #(.H_ACTIVE(640), .V_ACTIVE(480), .PIXEL_WIDTH(PW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_address(wr_address), .wr_data(wr_data),
    .done(done), .empty_cmd(empty_cmd), .pixel_count(pixel_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [43:0] wq[$];   // {address, data}
  logic [20:0] dq[$];   // {empty, count}

  int   cycn = 0;
  int   wcount = 0;
  int   last_done_cyc = -10;
  logic prev_wr_en = 1'b0;
  logic last_ready = 1'b0;
  logic expect_first = 1'b0;
  logic exp_first_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=event expected=none", tag);
  endtask

  // Sample at the falling edge, then return just after the next rising edge
  // so the caller drives inputs well clear of the active edge.
  task automatic cyc();
    logic [43:0] e;
    logic [20:0] d;
    @(negedge clock);
    cycn++;
    if (expect_first) begin
      chk("first_write", wr_en, exp_first_wr);
      chk("empty_done_next", done, !exp_first_wr);
      expect_first = 1'b0;
    end
    if (wr_en) begin
      if (wq.size() == 0) fail_now("unexpected_write");
      else begin
        e = wq[0];
        chk("wr_address", wr_address, e[43:24]);
        chk("wr_data", wr_data, e[23:0]);
        if (wr_ready) begin
          void'(wq.pop_front());
          wcount++;
        end
      end
    end
    if (wr_en || done) chk("cmd_ready_busy", cmd_ready, 1'b0);
    if (done) begin
      if (dq.size() == 0) fail_now("unexpected_done");
      else begin
        d = dq.pop_front();
        chk("pixel_count", pixel_count, d[19:0]);
        chk("empty_cmd", empty_cmd, d[20]);
        chk("done_follows_writes", prev_wr_en, (d[19:0] != 0));
        last_done_cyc = cycn;
      end
    end
    prev_wr_en = wr_en;
    last_ready = cmd_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [PW-1:0] color, output int acc_cyc);
    int  n;
    int  xe;
    int  ye;
    bit  ok;
    n  = 0;
    xe = (x1 > 639) ? 639 : x1;
    ye = (y1 > 479) ? 479 : y1;
    if (!(x0 > x1 || y0 > y1 || x0 >= 640 || y0 >= 480)) begin
      for (int yy = y0; yy <= ye; yy++)
        for (int xx = x0; xx <= xe; xx++) begin
          wq.push_back({10'(yy), 10'(xx), color});
          n++;
        end
    end
    dq.push_back({(n == 0), 20'(n)});
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = color;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      cyc();
      if (last_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
    acc_cyc = cycn;
    cmd_valid = 1'b0;
    expect_first = 1'b1;
    exp_first_wr = (n > 0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (wq.size() == 0 && dq.size() == 0) begin ok = 1'b1; break; end
      cyc();
    end
    if (!ok) fail_now("done_timeout");
  endtask

  initial begin
    int acc_a, acc_b, base;
    reset = 1'b0; cmd_valid = 1'b0; wr_ready = 1'b1;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_address", wr_address, 20'h0);
    chk("rst_wr_data", wr_data, 24'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_empty_cmd", empty_cmd, 1'b0);
    chk("rst_pixel_count", pixel_count, 20'h0);
    reset = 1'b1;
    cyc();
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Basic 3x2 fill
    send_cmd(2, 3, 4, 4, 24'hFF0000, acc_a);
    wait_done();

    // Clipped at the bottom-right corner
    send_cmd(638, 478, 700, 900, 24'h00FF00, acc_a);
    wait_done();

    // Empty commands
    send_cmd(5, 0, 4, 0, 24'h111111, acc_a);
    wait_done();
    send_cmd(640, 0, 645, 3, 24'h222222, acc_a);
    wait_done();

    // Backpressure on the second write of a 3-pixel row
    send_cmd(10, 20, 12, 20, 24'h0000FF, acc_a);
    cyc();
    wr_ready = 1'b0;
    cyc();
    cyc();
    wr_ready = 1'b1;
    wait_done();

    // Second command presented while the first is filling
    send_cmd(0, 0, 2, 1, 24'h123456, acc_a);
    send_cmd(50, 60, 50, 60, 24'hABCDEF, acc_b);
    chk("accept_after_done", acc_b, last_done_cyc + 1);
    wait_done();

    // Reset in the middle of a 100-pixel fill
    base = wcount;
    send_cmd(0, 0, 9, 9, 24'h0F0F0F, acc_a);
    for (int k = 0; k < 500; k++) begin
      if (wcount - base >= 10) break;
      cyc();
    end
    chk("writes_before_abort", wcount - base, 10);
    reset = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_pixel_count", pixel_count, 20'h0);
    chk("abort_cmd_ready", cmd_ready, 1'b0);
    wq.delete();
    dq.delete();
    expect_first = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    send_cmd(7, 7, 7, 7, 24'h808080, acc_a);
    wait_done();
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
